block_serial_borrow_skip_subtractor: RTL and testbench

//  Sequential N-bit subtractor computing diff = a - b - bin (unsigned), BLOCK_SIZE bits per cycle.

---
 rtl/block_serial_borrow_skip_subtractor_pkg.sv | 26 ++
 rtl/block_serial_borrow_skip_subtractor_if.sv | 24 ++
 rtl/block_serial_borrow_skip_subtractor_skip_borrow_block.sv | 30 +++
 rtl/block_serial_borrow_skip_subtractor.sv | 125 ++++++++++++
 tb/tb_block_serial_borrow_skip_subtractor.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/block_serial_borrow_skip_subtractor_pkg.sv
// rtl/block_serial_borrow_skip_subtractor_pkg.sv - shared state encoding and sizing helpers for the serial add/sub family
package block_serial_borrow_skip_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/block_serial_borrow_skip_subtractor_if.sv
// rtl/block_serial_borrow_skip_subtractor_if.sv - operand/result handshake bundle for the serial subtractor
interface block_serial_borrow_skip_subtractor_if #(
    parameter int N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] diff;
    logic         bout;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

// File: rtl/block_serial_borrow_skip_subtractor_skip_borrow_block.sv
// rtl/block_serial_borrow_skip_subtractor_skip_borrow_block.sv - combinational borrow-skip subtract slice
module block_serial_borrow_skip_subtractor_skip_borrow_block #(
    parameter int BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE-1:0] a_blk,
    input  logic [BLOCK_SIZE-1:0] b_blk,
    input  logic                  bi,
    output logic [BLOCK_SIZE-1:0] d_blk,
    output logic                  bo
);
    logic [BLOCK_SIZE:0]   br;
    logic [BLOCK_SIZE-1:0] p;

    assign p = ~(a_blk ^ b_blk);

    // Ripple borrow chain: bit i borrows when a<b, or when equal and a borrow arrives
    always_comb begin
        br    = '0;
        d_blk = '0;
        br[0] = bi;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            d_blk[i]  = a_blk[i] ^ b_blk[i] ^ br[i];
            br[i+1]   = (~a_blk[i] & b_blk[i]) | (p[i] & br[i]);
        end
    end

    // When every bit propagates, the incoming borrow bypasses the chain
    assign bo = (&p) ? bi : br[BLOCK_SIZE];

endmodule

// File: rtl/block_serial_borrow_skip_subtractor.sv
// rtl/block_serial_borrow_skip_subtractor.sv - multi-cycle a-b-bin, one borrow-skip block per cycle
module block_serial_borrow_skip_subtractor
    import block_serial_borrow_skip_subtractor_pkg::*;
#(
    parameter int N          = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic clk,
    input  logic rst,
    block_serial_borrow_skip_subtractor_if.slave s
);
    // A block wider than the operand collapses to the operand width; the
    // single pass is identical to a zero-padded wide block.
    localparam int BLK_W      = (BLOCK_SIZE > N) ? N : BLOCK_SIZE;
    localparam int NUM_BLOCKS = ceil_div(N, BLK_W);
    localparam int CNT_W      = (NUM_BLOCKS > 1) ? clog2(NUM_BLOCKS) : 1;
    localparam int PAD_W      = NUM_BLOCKS * BLK_W;
    localparam logic [CNT_W-1:0] LAST_BLK = CNT_W'(NUM_BLOCKS - 1);

    state_t             state;
    logic [CNT_W-1:0]   blk_cnt;
    logic [N-1:0]       a_q;
    logic [N-1:0]       b_q;
    logic [N-1:0]       diff_q;
    logic               borrow;
    logic               bout_q;
    logic               out_valid_q;

    logic [PAD_W-1:0]   a_pad;
    logic [PAD_W-1:0]   b_pad;
    logic [BLK_W-1:0]   a_blk;
    logic [BLK_W-1:0]   b_blk;
    logic [BLK_W-1:0]   d_blk;
    logic               blk_bo;
    logic [N-1:0]       diff_nxt;
    logic               accept;

    // Zero padding above bit N-1 has p_i=1 in every padded bit, so the borrow
    // out of bit N-1 passes through unchanged and becomes the block borrow-out.
    assign a_pad = PAD_W'(a_q);
    assign b_pad = PAD_W'(b_q);
    assign a_blk = a_pad[int'(blk_cnt) * BLK_W +: BLK_W];
    assign b_blk = b_pad[int'(blk_cnt) * BLK_W +: BLK_W];

    block_serial_borrow_skip_subtractor_skip_borrow_block #(
        .BLOCK_SIZE (BLK_W)
    ) u_blk (
        .a_blk (a_blk),
        .b_blk (b_blk),
        .bi    (borrow),
        .d_blk (d_blk),
        .bo    (blk_bo)
    );

    // Merge the current block's difference into its slice; padded bits are dropped
    always_comb begin
        diff_nxt = diff_q;
        for (int i = 0; i < N; i++) begin
            if ((i / BLK_W) == int'(blk_cnt)) begin
                diff_nxt[i] = d_blk[i % BLK_W];
            end
        end
    end

    assign s.in_ready  = (state == IDLE) | ((state == DONE) & s.out_ready);
    assign accept      = s.in_valid & s.in_ready;
    assign s.out_valid = out_valid_q;
    assign s.diff      = diff_q;
    assign s.bout      = bout_q;

    // Control FSM with operand capture, block sequencing and result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            blk_cnt     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            diff_q      <= '0;
            borrow      <= 1'b0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q     <= s.a;
                        b_q     <= s.b;
                        borrow  <= s.bin;
                        blk_cnt <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    diff_q <= diff_nxt;
                    borrow <= blk_bo;
                    if (blk_cnt == LAST_BLK) begin
                        bout_q      <= blk_bo;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        blk_cnt <= blk_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (s.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (s.in_valid) begin
                            a_q     <= s.a;
                            b_q     <= s.b;
                            borrow  <= s.bin;
                            blk_cnt <= '0;
                            state   <= RUN;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_serial_borrow_skip_subtractor.sv
// tb/tb_block_serial_borrow_skip_subtractor.sv - scoreboard bench over four width/block configurations
module tb_block_serial_borrow_skip_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   nchk = 0;
    int   nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    block_serial_borrow_skip_subtractor_if #(.N(8))  if8  ();
    block_serial_borrow_skip_subtractor_if #(.N(1))  if1  ();
    block_serial_borrow_skip_subtractor_if #(.N(10)) if10 ();
    block_serial_borrow_skip_subtractor_if #(.N(12)) if12 ();

    block_serial_borrow_skip_subtractor #(.N(8),  .BLOCK_SIZE(4)) u8  (.clk(clk), .rst(rst), .s(if8));
    block_serial_borrow_skip_subtractor #(.N(1),  .BLOCK_SIZE(6)) u1  (.clk(clk), .rst(rst), .s(if1));
    block_serial_borrow_skip_subtractor #(.N(10), .BLOCK_SIZE(4)) u10 (.clk(clk), .rst(rst), .s(if10));
    block_serial_borrow_skip_subtractor #(.N(12), .BLOCK_SIZE(4)) u12 (.clk(clk), .rst(rst), .s(if12));

    typedef struct {
        int          sel;
        logic [31:0] d;
        logic        b;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   nblk[4] = '{2, 1, 3, 3};
    bit   pv[4];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void get_out(input int s, output logic ov, output logic [31:0] d,
                                    output logic bo, output logic ordy);
        ov = 1'b0; d = '0; bo = 1'b0; ordy = 1'b0;
        case (s)
            0: begin ov = if8.out_valid;  d = 32'(if8.diff);  bo = if8.bout;  ordy = if8.out_ready;  end
            1: begin ov = if1.out_valid;  d = 32'(if1.diff);  bo = if1.bout;  ordy = if1.out_ready;  end
            2: begin ov = if10.out_valid; d = 32'(if10.diff); bo = if10.bout; ordy = if10.out_ready; end
            default: begin ov = if12.out_valid; d = 32'(if12.diff); bo = if12.bout; ordy = if12.out_ready; end
        endcase
    endfunction

    function automatic logic get_ready(input int s);
        case (s)
            0: return if8.in_ready;
            1: return if1.in_ready;
            2: return if10.in_ready;
            default: return if12.in_ready;
        endcase
    endfunction

    task automatic set_in(input int s, input logic v, input logic [31:0] a, input logic [31:0] b, input logic bin);
        case (s)
            0: begin if8.in_valid = v;  if8.a = a[7:0];   if8.b = b[7:0];   if8.bin = bin;  end
            1: begin if1.in_valid = v;  if1.a = a[0:0];   if1.b = b[0:0];   if1.bin = bin;  end
            2: begin if10.in_valid = v; if10.a = a[9:0];  if10.b = b[9:0];  if10.bin = bin; end
            default: begin if12.in_valid = v; if12.a = a[11:0]; if12.b = b[11:0]; if12.bin = bin; end
        endcase
    endtask

    task automatic send(input int s, input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [31:0] ed, input logic eb);
        int   n;
        logic ir;
        exp_t e;
        @(posedge clk); #1;
        set_in(s, 1'b1, a, b, bin);
        n = 0;
        do begin
            @(negedge clk);
            ir = get_ready(s);
            n++;
        end while (!ir && n < 50);
        if (!ir) begin
            nchk++; nfail++;
            $display("FAIL accept_timeout: dut %0d in_ready stayed 0, required 1", s);
        end else begin
            e.sel = s; e.d = ed; e.b = eb; e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk); #1;
        set_in(s, 1'b0, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("in_ready_run", 32'(get_ready(s)), 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            nchk++; nfail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic op(input int s, input logic [31:0] a, input logic [31:0] b, input logic bin,
                      input logic [31:0] ed, input logic eb);
        send(s, a, b, bin, ed, eb);
        drain();
    endtask

    // Monitor: latency on each rising out_valid, value check on each accepted result
    always @(negedge clk) begin
        logic        ov, bo, ordy;
        logic [31:0] d;
        exp_t        e;
        for (int s = 0; s < 4; s++) begin
            get_out(s, ov, d, bo, ordy);
            if (!rst) begin
                if (ov && !pv[s]) begin
                    if (q.size() == 0 || q[0].sel != s) begin
                        nchk++; nfail++;
                        $display("FAIL unexpected_out: dut %0d out_valid=1, required 0", s);
                    end else begin
                        chk("latency", 32'(cyc - q[0].acc), 32'(nblk[s]));
                    end
                end
                if (ov && ordy && q.size() != 0 && q[0].sel == s) begin
                    e = q.pop_front();
                    chk("diff", d, e.d);
                    chk("bout", 32'(bo), 32'(e.b));
                end
            end
            pv[s] = ov;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ov, bo, ordy;
        logic [31:0] d;
        logic [7:0]  t1d, t1b;
        logic [2:0]  v;
        int          n;
        bit          stale;
        exp_t        e;

        for (int s = 0; s < 4; s++) set_in(s, 1'b0, 32'd0, 32'd0, 1'b0);
        if8.out_ready = 1'b1; if1.out_ready = 1'b1; if10.out_ready = 1'b1; if12.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state on every configuration
        @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            get_out(s, ov, d, bo, ordy);
            chk("rst_out_valid", 32'(ov), 32'd0);
            chk("rst_diff", d, 32'd0);
            chk("rst_bout", 32'(bo), 32'd0);
            chk("rst_in_ready", 32'(get_ready(s)), 32'd1);
        end

        // N=8, BLOCK_SIZE=4
        op(0, 32'h35, 32'h12, 1'b0, 32'h23, 1'b0);
        op(0, 32'h00, 32'h01, 1'b0, 32'hFF, 1'b1);
        op(0, 32'hA0, 32'h0F, 1'b1, 32'h90, 1'b0);
        op(0, 32'h12, 32'h35, 1'b0, 32'hDD, 1'b1);

        // N=1, BLOCK_SIZE=6: bit i of the tables is the result for {a,b,bin}=i
        t1d = 8'b10010110;
        t1b = 8'b10001110;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            op(1, 32'(v[2]), 32'(v[1]), v[0], 32'(t1d[i]), t1b[i]);
        end

        // N=10, BLOCK_SIZE=4 with a partial top block
        op(2, 32'h000, 32'h3FF, 1'b1, 32'h000, 1'b1);
        op(2, 32'h200, 32'h001, 1'b0, 32'h1FF, 1'b0);
        op(2, 32'h3FF, 32'h000, 1'b1, 32'h3FE, 1'b0);

        // N=12, BLOCK_SIZE=4
        op(3, 32'hABC, 32'h123, 1'b0, 32'h999, 1'b0);
        op(3, 32'h800, 32'h800, 1'b1, 32'hFFF, 1'b1);

        // Hold the result, then accept the next operation in the release cycle
        @(posedge clk); #1 if8.out_ready = 1'b0;
        send(0, 32'h80, 32'h01, 1'b0, 32'h7F, 1'b0);
        n = 0;
        while (!if8.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("hold_reached_done", 32'(if8.out_valid), 32'd1);
        @(posedge clk); #1;
        set_in(0, 1'b1, 32'h0F, 32'h10, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_diff", 32'(if8.diff), 32'h7F);
            chk("hold_bout", 32'(if8.bout), 32'd0);
            chk("hold_out_valid", 32'(if8.out_valid), 32'd1);
            chk("hold_in_ready", 32'(if8.in_ready), 32'd0);
        end
        @(posedge clk); #1 if8.out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(if8.in_ready), 32'd1);
        e.sel = 0; e.d = 32'hFE; e.b = 1'b1; e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        set_in(0, 1'b0, 32'd0, 32'd0, 1'b0);
        drain();

        // Reset during the second RUN cycle of N=12 discards the operation
        @(posedge clk); #1;
        set_in(3, 1'b1, 32'h0F5, 32'h001, 1'b0);
        @(negedge clk);
        chk("abort_accept_ready", 32'(if12.in_ready), 32'd1);
        @(posedge clk); #1;
        set_in(3, 1'b0, 32'd0, 32'd0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", 32'(if12.out_valid), 32'd0);
        chk("abort_diff", 32'(if12.diff), 32'd0);
        chk("abort_bout", 32'(if12.bout), 32'd0);
        chk("abort_in_ready", 32'(if12.in_ready), 32'd1);
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (if12.out_valid) stale = 1'b1;
        end
        chk("abort_no_stale", 32'(stale), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
